// File: rtl/pc_lr_stack_block.sv
// PC with link-register return stack (LR_STACK_EN: DEPTH-entry stack, else one LR); state updates on Clock,
// SysBus drive and PcIncCout are combinational. No backpressure; Stall freezes every register for the cycle.
module pc_lr_stack_block #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  inout  wire  [WIDTH-1:0] SysBus,
  input  logic [WIDTH-1:0] ALU,
  input  logic             PcIncCin,
  input  logic             PcWe,
  input  logic [1:0]       PcSel,
  input  logic             PcEn,
  input  logic             LrWe,
  input  logic             LrSel,
  input  logic             LrPop,
  input  logic             LrEn,
  input  logic             Stall,
  output logic [WIDTH-1:0] Pc,
  output logic             PcIncCout,
  output logic             LrFull,
  output logic             LrEmpty,
  output logic             LrErr
);

  logic [WIDTH:0]   incSum;
  logic [WIDTH-1:0] pcInc;
  logic [WIDTH-1:0] pushDat;
  logic [WIDTH-1:0] topVal;
  logic [WIDTH-1:0] pcNext;
  logic [WIDTH-1:0] busDat;
  logic             busDrv;

  assign incSum    = {1'b0, Pc} + {{WIDTH{1'b0}}, PcIncCin};
  assign pcInc     = incSum[WIDTH-1:0];
  assign PcIncCout = incSum[WIDTH];
  assign pushDat   = LrSel ? SysBus : pcInc;

`ifdef LR_STACK_EN
  localparam int SpW  = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] lrMem [DEPTH];
  logic [SpW-1:0]   sp;
  logic [SpW-1:0]   topIdx;
  logic [CntW-1:0]  count;

  // sp always points at the next free slot; when full that is also the oldest entry
  assign topIdx  = sp - SpW'(1);
  assign LrEmpty = (count == '0);
  assign LrFull  = (count == CntW'(DEPTH));
  assign topVal  = LrEmpty ? '0 : lrMem[topIdx];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sp    <= '0;
      count <= '0;
      LrErr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) lrMem[i] <= '0;
    end else if (!Stall) begin
      if (LrWe && LrPop && !LrEmpty) begin
        lrMem[topIdx] <= pushDat;
      end else if (LrWe) begin
        lrMem[sp] <= pushDat;
        sp        <= sp + SpW'(1);
        if (LrFull) LrErr <= 1'b1;
        else        count <= count + CntW'(1);
      end else if (LrPop) begin
        if (LrEmpty) begin
          LrErr <= 1'b1;
        end else begin
          sp    <= topIdx;
          count <= count - CntW'(1);
        end
      end
      if (PcWe && (PcSel == 2'b11) && LrEmpty) LrErr <= 1'b1;
    end
  end
`else
  logic [WIDTH-1:0] lrReg;
  logic             unusedPop;

  assign unusedPop = LrPop;
  assign topVal    = lrReg;
  assign LrFull    = 1'b0;
  assign LrEmpty   = 1'b0;
  assign LrErr     = 1'b0;

  always_ff @(posedge Clock) begin
    if (Reset)              lrReg <= '0;
    else if (!Stall && LrWe) lrReg <= pushDat;
  end
`endif

  always_comb begin
    pcNext = pcInc;
    case (PcSel)
      2'b00:   pcNext = pcInc;
      2'b01:   pcNext = SysBus;
      2'b10:   pcNext = ALU;
      default: pcNext = topVal;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset)               Pc <= RESET_VEC;
    else if (!Stall && PcWe) Pc <= pcNext;
  end

  assign busDrv = PcEn | LrEn;
  assign busDat = PcEn ? Pc : topVal;
  assign SysBus = busDrv ? busDat : {WIDTH{1'bz}};

  // Sampling the bus we are driving ourselves would just loop our own value back
  assert property (@(posedge Clock) disable iff (Reset)
    busDrv |-> !((PcWe && (PcSel == 2'b01)) || (LrWe && LrSel)))
    else $error("SysBus sampled while this block drives it");

  assert property (@(posedge Clock) (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0))
    else $error("DEPTH must be a power of two, at least 2");

endmodule
